// File: rtl/alarm_pkg.sv
// alarm_pkg: shared types for the alarm scheduler.
//   alarm_state_t   per-channel FSM state (IDLE, ARMED)
//   MODE_*          2-bit channel mode encodings (2'b11 is reserved and
//                   behaves as ONESHOT_EQ)
//   alarm_status_t  registered per-channel outputs bundled for the top level
package alarm_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } alarm_state_t;

  localparam logic [1:0] MODE_ONESHOT_EQ  = 2'b00;
  localparam logic [1:0] MODE_PERIODIC_EQ = 2'b01;
  localparam logic [1:0] MODE_ONESHOT_GE  = 2'b10;

  typedef struct packed {
    logic alarm;    // one-cycle fire pulse
    logic pending;  // sticky fired flag
    logic overrun;  // fired while already pending
    logic armed;    // FSM is in ARMED
  } alarm_status_t;

endpackage

// File: rtl/alarm_channel.sv
// alarm_channel: one alarm channel -- FSM, target register, comparator,
// periodic reloader and sticky pending/overrun flags.
//   clk_i, rst_i   clock, synchronous active-high reset
//   en_i           channel enable; low forces IDLE and suppresses firing
//   mode_i         channel mode (see alarm_pkg)
//   arm_i          latch alarm_i into the target and arm
//   alarm_i        target value
//   period_i       reload increment, sampled at each reload
//   counter_i      counter value compared against the target
//   ack_i          clears pending/overrun (a coincident fire wins)
//   status_o       registered alarm/pending/overrun/armed
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int W = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic [1:0]    mode_i,
  input  logic          arm_i,
  input  logic [W-1:0]  alarm_i,
  input  logic [W-1:0]  period_i,
  input  logic [W-1:0]  counter_i,
  input  logic          ack_i,
  output alarm_status_t status_o
);

  // Distances below half the counter range count as "at or past target".
  localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

  alarm_state_t state_q;
  logic [W-1:0] target_q;
  logic [W-1:0] diff;
  logic         alarm_q, pending_q, overrun_q;
  logic         hit, fire, reload;

  always_comb begin
    diff = counter_i - target_q;
    if (mode_i == MODE_ONESHOT_GE) hit = (diff < HALF);
    else                           hit = (counter_i == target_q);
    // A coincident arm takes priority over a match.
    fire   = en_i && (state_q == ARMED) && !arm_i && hit;
    // Period 0 would re-fire forever on the same target: treat as one-shot.
    reload = (mode_i == MODE_PERIODIC_EQ) && (period_i != '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      target_q  <= '0;
      alarm_q   <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      alarm_q <= fire;

      if (!en_i) begin
        state_q <= IDLE;
      end else if (arm_i) begin
        state_q  <= ARMED;
        target_q <= alarm_i;
      end else if (fire) begin
        if (reload) target_q <= target_q + period_i;
        else        state_q  <= IDLE;
      end

      // Set beats ack; overrun is re-derived from the pre-ack pending state.
      if (fire) begin
        pending_q <= 1'b1;
        overrun_q <= pending_q | (overrun_q & ~ack_i);
      end else if (ack_i) begin
        pending_q <= 1'b0;
        overrun_q <= 1'b0;
      end
    end
  end

  assign status_o.alarm   = alarm_q;
  assign status_o.pending = pending_q;
  assign status_o.overrun = overrun_q;
  assign status_o.armed   = (state_q == ARMED);

endmodule

// File: rtl/alarm_scheduler.sv
// alarm_scheduler: multi-channel programmable alarm unit.
// Slices the flat per-channel buses, runs NB_CAPTURES independent
// alarm_channel instances and registers the aggregated interrupt.
//   clk_i, rst_i   clock, synchronous active-high reset
//   alarm_en_i     per-channel enable
//   mode_i         per-channel mode, slice [2i+:2]
//   arm_i          per-channel arm strobe
//   alarm_i        per-channel target, slice [W*i+:W]
//   period_i       per-channel reload increment
//   counter_i      per-channel counter value
//   ack_i          per-channel pending/overrun clear
//   alarm_o        one-cycle fire pulses
//   pending_o      sticky fired flags
//   overrun_o      sticky fired-while-pending flags
//   armed_o        channel is ARMED
//   irq_o          registered OR of pending_o (one cycle behind it)
module alarm_scheduler
  import alarm_pkg::*;
#(
  parameter int TIMER_BITWIDTH = 32,
  parameter int NB_CAPTURES    = 10
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NB_CAPTURES-1:0]               alarm_en_i,
  input  logic [2*NB_CAPTURES-1:0]             mode_i,
  input  logic [NB_CAPTURES-1:0]               arm_i,
  input  logic [TIMER_BITWIDTH*NB_CAPTURES-1:0] alarm_i,
  input  logic [TIMER_BITWIDTH*NB_CAPTURES-1:0] period_i,
  input  logic [TIMER_BITWIDTH*NB_CAPTURES-1:0] counter_i,
  input  logic [NB_CAPTURES-1:0]               ack_i,
  output logic [NB_CAPTURES-1:0]               alarm_o,
  output logic [NB_CAPTURES-1:0]               pending_o,
  output logic [NB_CAPTURES-1:0]               overrun_o,
  output logic [NB_CAPTURES-1:0]               armed_o,
  output logic                                 irq_o
);

  localparam int W  = TIMER_BITWIDTH;
  localparam int NB = NB_CAPTURES;

  logic [NB-1:0][W-1:0] alarm_v, period_v, counter_v;
  logic [NB-1:0][1:0]   mode_v;
  alarm_status_t [NB-1:0] st;
  logic irq_q;

  assign alarm_v   = alarm_i;
  assign period_v  = period_i;
  assign counter_v = counter_i;
  assign mode_v    = mode_i;

  for (genvar g = 0; g < NB; g++) begin : g_ch
    alarm_channel #(.W(W)) u_ch (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .en_i      (alarm_en_i[g]),
      .mode_i    (mode_v[g]),
      .arm_i     (arm_i[g]),
      .alarm_i   (alarm_v[g]),
      .period_i  (period_v[g]),
      .counter_i (counter_v[g]),
      .ack_i     (ack_i[g]),
      .status_o  (st[g])
    );
    assign alarm_o[g]   = st[g].alarm;
    assign pending_o[g] = st[g].pending;
    assign overrun_o[g] = st[g].overrun;
    assign armed_o[g]   = st[g].armed;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) irq_q <= 1'b0;
    else       irq_q <= |pending_o;
  end

  assign irq_o = irq_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
module tb_alarm_scheduler;
  localparam int W    = 8;
  localparam int NB   = 4;
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [NB-1:0]   en, arm, ack;
  logic [2*NB-1:0] mode;
  logic [W*NB-1:0] alarm_in, period, counter;
  logic [NB-1:0]   alarm_o, pending_o, overrun_o, armed_o;
  logic            irq_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alarm_scheduler #(.TIMER_BITWIDTH(W), .NB_CAPTURES(NB)) dut (
    .clk_i(clk), .rst_i(rst), .alarm_en_i(en), .mode_i(mode), .arm_i(arm),
    .alarm_i(alarm_in), .period_i(period), .counter_i(counter), .ack_i(ack),
    .alarm_o(alarm_o), .pending_o(pending_o), .overrun_o(overrun_o),
    .armed_o(armed_o), .irq_o(irq_o)
  );

  // Reference model: per-channel behaviour from the rules, one call per clock.
  bit [NB-1:0] m_alarm, m_pend, m_ovr, m_armed;
  bit          m_irq;
  int          m_target[NB];

  function automatic void model_step();
    bit [NB-1:0] p_before;
    p_before = m_pend;
    if (rst) begin
      m_alarm = '0; m_pend = '0; m_ovr = '0; m_armed = '0; m_irq = 0;
      for (int c = 0; c < NB; c++) m_target[c] = 0;
      return;
    end
    for (int c = 0; c < NB; c++) begin
      int cv, t, md, per;
      bit hit, fire;
      cv  = int'(counter[c*W +: W]);
      t   = m_target[c];
      md  = int'(mode[2*c +: 2]);
      per = int'(period[c*W +: W]);
      hit = (md == 2) ? (((cv - t) & MASK) < (1 << (W-1))) : (cv == t);
      fire = 0;
      m_alarm[c] = 0;
      if (!en[c]) m_armed[c] = 0;
      else if (arm[c]) begin
        m_armed[c]  = 1;
        m_target[c] = int'(alarm_in[c*W +: W]);
      end else if (m_armed[c] && hit) fire = 1;
      if (fire) begin
        m_alarm[c] = 1;
        if (md == 1 && per != 0) m_target[c] = (t + per) & MASK;
        else m_armed[c] = 0;
        m_ovr[c]  = p_before[c] ? 1'b1 : (ack[c] ? 1'b0 : m_ovr[c]);
        m_pend[c] = 1;
      end else if (ack[c]) begin
        m_pend[c] = 0;
        m_ovr[c]  = 0;
      end
    end
    m_irq = |p_before;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [1:0] md, input int tgt, input int per);
    mode[2*c +: 2]     = md;
    alarm_in[c*W +: W] = tgt[W-1:0];
    period[c*W +: W]   = per[W-1:0];
  endtask

  task automatic set_cnt(input int c, input int v);
    counter[c*W +: W] = v[W-1:0];
  endtask

  task automatic do_rst();
    rst = 1; en = '0; arm = '0; ack = '0; mode = '0;
    alarm_in = '0; period = '0; counter = '0;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_rst();
    checks += 5;
    if (alarm_o !== '0)   begin errors++; $display("FAIL reset_alarm got %b exp 0", alarm_o); end
    if (pending_o !== '0) begin errors++; $display("FAIL reset_pending got %b exp 0", pending_o); end
    if (overrun_o !== '0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun_o); end
    if (armed_o !== '0)   begin errors++; $display("FAIL reset_armed got %b exp 0", armed_o); end
    if (irq_o !== 1'b0)   begin errors++; $display("FAIL reset_irq got %b exp 0", irq_o); end
  endtask

  task automatic test_oneshot_eq();
    do_rst();
    en = '1;
    set_ch(0, 2'b00, 100, 0); set_cnt(0, 90); arm[0] = 1;
    tick();
    arm[0] = 0;
    for (int v = 91; v <= 110; v++) begin
      set_cnt(0, v);
      tick();
      checks++;
      if (alarm_o[0] !== (v == 100)) begin
        errors++; $display("FAIL oneshot_alarm cnt %0d got %b exp %b", v, alarm_o[0], v == 100);
      end
    end
    checks += 2;
    if (pending_o[0] !== 1'b1) begin errors++; $display("FAIL oneshot_pending got %b exp 1", pending_o[0]); end
    if (armed_o[0] !== 1'b0)   begin errors++; $display("FAIL oneshot_armed got %b exp 0", armed_o[0]); end
  endtask

  task automatic test_periodic_eq();
    int np;
    bit exp_a;
    do_rst();
    en = '1;
    set_ch(1, 2'b01, 250, 10); set_cnt(1, 245); arm[1] = 1;
    tick();
    arm[1] = 0;
    np = 0;
    for (int k = 1; k <= 25; k++) begin
      int v;
      v = (245 + k) & MASK;
      set_cnt(1, v);
      tick();
      exp_a = (v == 250) || (v == 4) || (v == 14);
      if (exp_a) np++;
      checks += 2;
      if (alarm_o[1] !== exp_a) begin
        errors++; $display("FAIL periodic_alarm cnt %0d got %b exp %b", v, alarm_o[1], exp_a);
      end
      if (overrun_o[1] !== (np >= 2)) begin
        errors++; $display("FAIL periodic_overrun cnt %0d got %b exp %b", v, overrun_o[1], np >= 2);
      end
    end
    set_cnt(1, 100); ack[1] = 1;
    tick();
    ack[1] = 0;
    checks += 3;
    if (pending_o[1] !== 1'b0) begin errors++; $display("FAIL periodic_ack_pending got %b exp 0", pending_o[1]); end
    if (overrun_o[1] !== 1'b0) begin errors++; $display("FAIL periodic_ack_overrun got %b exp 0", overrun_o[1]); end
    if (armed_o[1] !== 1'b1)   begin errors++; $display("FAIL periodic_still_armed got %b exp 1", armed_o[1]); end
  endtask

  task automatic test_ge();
    do_rst();
    en = '1;
    set_ch(2, 2'b10, 50, 0); set_cnt(2, 60); arm[2] = 1;
    tick();
    arm[2] = 0;
    checks += 2;
    if (armed_o[2] !== 1'b1) begin errors++; $display("FAIL ge_armed got %b exp 1", armed_o[2]); end
    if (alarm_o[2] !== 1'b0) begin errors++; $display("FAIL ge_arm_cycle got %b exp 0", alarm_o[2]); end
    tick();
    checks += 3;
    if (alarm_o[2] !== 1'b1)   begin errors++; $display("FAIL ge_fire got %b exp 1", alarm_o[2]); end
    if (armed_o[2] !== 1'b0)   begin errors++; $display("FAIL ge_idle got %b exp 0", armed_o[2]); end
    if (pending_o[2] !== 1'b1) begin errors++; $display("FAIL ge_pending got %b exp 1", pending_o[2]); end
    tick();
    checks++;
    if (alarm_o[2] !== 1'b0) begin errors++; $display("FAIL ge_single got %b exp 0", alarm_o[2]); end
  endtask

  task automatic test_ge_wrap();
    int seq[9] = '{200, 130, 230, 249, 255, 0, 1, 2, 3};
    do_rst();
    en = '1;
    set_ch(2, 2'b10, 250, 0); set_cnt(2, 200); arm[2] = 1;
    tick();
    arm[2] = 0;
    for (int k = 0; k < 9; k++) begin
      set_cnt(2, seq[k]);
      tick();
      checks++;
      if (alarm_o[2] !== (seq[k] == 255)) begin
        errors++; $display("FAIL ge_wrap cnt %0d got %b exp %b", seq[k], alarm_o[2], seq[k] == 255);
      end
    end
    // Counter already past the target through the wrap: fires at once.
    set_cnt(2, 3); arm[2] = 1;
    tick();
    arm[2] = 0;
    tick();
    checks++;
    if (alarm_o[2] !== 1'b1) begin errors++; $display("FAIL ge_wrap_past got %b exp 1", alarm_o[2]); end
  endtask

  task automatic test_simultaneous();
    do_rst();
    en = '1;
    // arm coincident with a match: no pulse, new target taken
    set_ch(0, 2'b00, 10, 0); set_cnt(0, 0); arm[0] = 1;
    tick();
    set_ch(0, 2'b00, 20, 0); set_cnt(0, 10);
    tick();
    arm[0] = 0;
    checks += 2;
    if (alarm_o[0] !== 1'b0) begin errors++; $display("FAIL arm_match_alarm got %b exp 0", alarm_o[0]); end
    if (armed_o[0] !== 1'b1) begin errors++; $display("FAIL arm_match_armed got %b exp 1", armed_o[0]); end
    tick();
    checks++;
    if (alarm_o[0] !== 1'b0) begin errors++; $display("FAIL arm_match_old got %b exp 0", alarm_o[0]); end
    set_cnt(0, 20);
    tick();
    checks++;
    if (alarm_o[0] !== 1'b1) begin errors++; $display("FAIL arm_match_new got %b exp 1", alarm_o[0]); end
    // ack coincident with fire while pending
    set_ch(0, 2'b00, 30, 0); set_cnt(0, 0); arm[0] = 1;
    tick();
    arm[0] = 0; set_cnt(0, 30); ack[0] = 1;
    tick();
    checks += 3;
    if (alarm_o[0] !== 1'b1)   begin errors++; $display("FAIL ack_fire_alarm got %b exp 1", alarm_o[0]); end
    if (pending_o[0] !== 1'b1) begin errors++; $display("FAIL ack_fire_pending got %b exp 1", pending_o[0]); end
    if (overrun_o[0] !== 1'b1) begin errors++; $display("FAIL ack_fire_overrun got %b exp 1", overrun_o[0]); end
    set_cnt(0, 0);
    tick();
    ack[0] = 0;
    checks += 2;
    if (pending_o[0] !== 1'b0) begin errors++; $display("FAIL ack_pending got %b exp 0", pending_o[0]); end
    if (overrun_o[0] !== 1'b0) begin errors++; $display("FAIL ack_overrun got %b exp 0", overrun_o[0]); end
    // ack coincident with fire while not pending
    set_ch(0, 2'b00, 40, 0); arm[0] = 1;
    tick();
    arm[0] = 0; set_cnt(0, 40); ack[0] = 1;
    tick();
    ack[0] = 0;
    checks += 2;
    if (pending_o[0] !== 1'b1) begin errors++; $display("FAIL ack_fire2_pending got %b exp 1", pending_o[0]); end
    if (overrun_o[0] !== 1'b0) begin errors++; $display("FAIL ack_fire2_overrun got %b exp 0", overrun_o[0]); end
    // enable dropped while armed
    set_ch(0, 2'b00, 90, 0); set_cnt(0, 0); arm[0] = 1;
    tick();
    arm[0] = 0; en[0] = 0;
    tick();
    checks += 2;
    if (armed_o[0] !== 1'b0)   begin errors++; $display("FAIL en_drop_armed got %b exp 0", armed_o[0]); end
    if (pending_o[0] !== 1'b1) begin errors++; $display("FAIL en_drop_pending got %b exp 1", pending_o[0]); end
    en[0] = 1; set_cnt(0, 90);
    tick();
    checks++;
    if (alarm_o[0] !== 1'b0) begin errors++; $display("FAIL en_drop_nofire got %b exp 0", alarm_o[0]); end
  endtask

  task automatic test_back_to_back_reset();
    do_rst();
    en = '1;
    for (int c = 0; c < NB; c++) begin set_ch(c, 2'b01, 5, 1); set_cnt(c, 3); end
    arm = '1;
    tick();
    arm = '0;
    for (int v = 4; v <= 15; v++) begin
      for (int c = 0; c < NB; c++) set_cnt(c, v);
      tick();
      checks += 2;
      if (alarm_o !== {NB{v >= 5}}) begin
        errors++; $display("FAIL b2b_alarm cnt %0d got %b exp %b", v, alarm_o, {NB{v >= 5}});
      end
      if (irq_o !== (v >= 6)) begin
        errors++; $display("FAIL b2b_irq cnt %0d got %b exp %b", v, irq_o, v >= 6);
      end
    end
    rst = 1; arm = '1;
    for (int c = 0; c < NB; c++) set_cnt(c, 16);
    tick();
    rst = 0; arm = '0;
    checks += 5;
    if (alarm_o !== '0)   begin errors++; $display("FAIL midrst_alarm got %b exp 0", alarm_o); end
    if (pending_o !== '0) begin errors++; $display("FAIL midrst_pending got %b exp 0", pending_o); end
    if (overrun_o !== '0) begin errors++; $display("FAIL midrst_overrun got %b exp 0", overrun_o); end
    if (armed_o !== '0)   begin errors++; $display("FAIL midrst_armed got %b exp 0", armed_o); end
    if (irq_o !== 1'b0)   begin errors++; $display("FAIL midrst_irq got %b exp 0", irq_o); end
    for (int v = 17; v <= 21; v++) begin
      for (int c = 0; c < NB; c++) set_cnt(c, (v == 19) ? 0 : v);
      tick();
      checks++;
      if (alarm_o !== '0 || armed_o !== '0) begin
        errors++; $display("FAIL postrst_quiet cnt %0d alarm %b armed %b exp 0", v, alarm_o, armed_o);
      end
    end
  endtask

  task automatic test_random();
    do_rst();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rst = ($urandom_range(0, 249) == 0);
      for (int c = 0; c < NB; c++) begin
        en[c]  = ($urandom_range(0, 29) != 0);
        arm[c] = ($urandom_range(0, 11) == 0);
        ack[c] = ($urandom_range(0, 9) == 0);
        if (arm[c]) begin
          mode[2*c +: 2]     = 2'($urandom_range(0, 3));
          alarm_in[c*W +: W] = W'(int'(counter[c*W +: W]) + int'($urandom_range(0, 12)));
          period[c*W +: W]   = W'($urandom_range(0, 6));
        end
        if ($urandom_range(0, 9) == 0) counter[c*W +: W] = W'($urandom);
        else counter[c*W +: W] = counter[c*W +: W] + 1'b1;
      end
      tick();
      checks += 5;
      if (alarm_o !== m_alarm)   begin errors++; $display("FAIL rand_alarm cyc %0d got %b exp %b", cyc, alarm_o, m_alarm); end
      if (pending_o !== m_pend)  begin errors++; $display("FAIL rand_pending cyc %0d got %b exp %b", cyc, pending_o, m_pend); end
      if (overrun_o !== m_ovr)   begin errors++; $display("FAIL rand_overrun cyc %0d got %b exp %b", cyc, overrun_o, m_ovr); end
      if (armed_o !== m_armed)   begin errors++; $display("FAIL rand_armed cyc %0d got %b exp %b", cyc, armed_o, m_armed); end
      if (irq_o !== m_irq)       begin errors++; $display("FAIL rand_irq cyc %0d got %b exp %b", cyc, irq_o, m_irq); end
    end
    rst = 0;
  endtask

  initial begin
    rst = 1; en = '0; arm = '0; ack = '0; mode = '0;
    alarm_in = '0; period = '0; counter = '0;
    #2;
    test_reset();
    test_oneshot_eq();
    test_periodic_eq();
    test_ge();
    test_ge_wrap();
    test_simultaneous();
    test_back_to_back_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_scheduler.md
# alarm_scheduler

Multi-channel programmable alarm unit for the timer subsystem. It compares each channel's free-running counter against a per-channel target latched at arm time. On a match it emits a one-cycle alarm pulse, sets a sticky pending flag and raises an aggregated interrupt. Periodic channels auto-reload their target by a programmed period, so the block replaces the plain equality alarm stage behind the counter/capture bank with one-shot, periodic and wrap-safe "late" compare modes.

## Interface
- `TIMER_BITWIDTH`, 32: width of every counter, target and period.
- `NB_CAPTURES`, 10: number of alarm channels.
- `clk_i`  in  1: the single clock.
- `rst_i`  in  1: reset, synchronous, active-high.
- `alarm_en_i`  in  NB_CAPTURES: per-channel enable.
- `mode_i`  in  2*NB_CAPTURES: per-channel mode in slice [2i+:2].
  - 00: ONESHOT_EQ.
  - 01: PERIODIC_EQ.
  - 10: ONESHOT_GE.
  - 11: reserved, behaves as ONESHOT_EQ.
- `arm_i`  in  NB_CAPTURES: one-cycle strobe that latches `alarm_i` slice into the target and arms the channel.
- `alarm_i`  in  TIMER_BITWIDTH*NB_CAPTURES: target value per channel.
- `period_i`  in  TIMER_BITWIDTH*NB_CAPTURES: reload increment per channel, sampled at every reload.
- `counter_i`  in  TIMER_BITWIDTH*NB_CAPTURES: counter value per channel.
- `ack_i`  in  NB_CAPTURES: clears pending and overrun for the channel.
- `alarm_o`  out  NB_CAPTURES: one-cycle fire pulse.
- `pending_o`  out  NB_CAPTURES: sticky fired flag.
- `overrun_o`  out  NB_CAPTURES: sticky flag, fired while already pending.
- `armed_o`  out  NB_CAPTURES: channel state is ARMED.
- `irq_o`  out  1: OR of `pending_o`, registered.

## Operation
- Each channel has two states: IDLE and ARMED.
- Reset forces every channel to IDLE and target to 0. All outputs reset to 0.
- IDLE -> ARMED when `arm_i[i]` and `alarm_en_i[i]` are both high; target <= `alarm_i` slice.
- `arm_i` while `alarm_en_i` is low is ignored.
- `alarm_en_i[i]` low forces IDLE and suppresses `alarm_o[i]`. Pending and overrun are retained.
- Match condition, evaluated only in ARMED:
  - EQ modes: `counter == target`.
  - GE mode: MSB of (`counter - target`) mod 2^W is 0. This is a wrap-safe "counter at or past target", valid while the distance is < 2^(W-1).
- On a match:
  - `alarm_o[i]` pulses, `pending_o[i]` is set.
  - If pending was already 1, `overrun_o[i]` is also set.
- One-shot modes: match -> IDLE.
- PERIODIC_EQ: match -> stay ARMED, target <= target + `period_i` slice, mod 2^W, wrapping silently.
- PERIODIC_EQ with period 0 behaves as one-shot: fires once, then goes to IDLE.
- `arm_i` while ARMED re-arms with the new target. If it coincides with a match, arm wins: no fire, new target loaded.
- `ack_i` coincident with a fire: set wins. Pending stays 1; overrun is cleared, then re-evaluated against the pre-ack pending state (set if pending was 1).
- Channels are fully independent; no arbitration between them.

## Timing
- Compare is registered. `counter_i` matching in cycle n gives `alarm_o` high in cycle n+1 for exactly one cycle.
- `pending_o`, `overrun_o` and `armed_o` update in cycle n+1.
- `irq_o` updates in cycle n+2.
- Periodic reload takes effect in cycle n+1. A counter advancing by 1 per cycle with period ≥ 1 therefore never misses the next match.
- `ack_i` in cycle m clears pending in cycle m+1.
- `rst_i` mid-operation: in the next cycle all state is IDLE and all outputs are 0, regardless of other inputs.
- Pulse back-to-back: period 1 with the counter incrementing every cycle gives `alarm_o` high continuously.

## Structure
- Package `alarm_pkg` holds:
  - the state enum `alarm_state_t` (IDLE, ARMED);
  - the mode constants `MODE_ONESHOT_EQ`, `MODE_PERIODIC_EQ`, `MODE_ONESHOT_GE`.
- Sub-module `alarm_channel` holds one channel's FSM, target register, comparator, reloader and sticky flags.
- The top level slices the flat buses, instantiates `NB_CAPTURES` channels in a generate loop and registers `irq_o`.

## Test plan
- ONESHOT_EQ, ch0: arm with target 100, counter increments from 90.
  - Required: `alarm_o[0]` high exactly one cycle, the cycle after counter = 100.
  - Required: `pending_o[0]` = 1, `armed_o[0]` = 0, no further pulses.
- PERIODIC_EQ, ch1, W=8: target 250, period 10.
  - Required: pulses follow counter 250, 4 (wrap), 14.
  - Required: overrun set on the 2nd pulse with no ack; ack clears both flags.
- ONESHOT_GE, ch2: arm with target 50 while counter = 60.
  - Required: fires on the next evaluation.
- ONESHOT_GE, W=8: target 250, counter 255 -> 3 passes through wrap.
  - Required: fires at 255, not earlier.
- Simultaneous events:
  - arm and match in the same cycle: no pulse, new target loaded;
  - ack and fire in the same cycle: pending remains 1;
  - `alarm_en_i` dropped while ARMED: IDLE, pending retained.
- `rst_i` asserted mid-periodic run on all channels.
  - Required: next cycle all outputs 0 and `armed_o` 0; no pulse until re-armed.
